// File: rtl/cpu_pkg.sv
// Shared constants and types for the 16-bit pipelined CPU: word width,
// reset PC, halt opcode and the fetch-stage state encoding.
package cpu_pkg;

    localparam int XLEN = 16;
    localparam logic [XLEN-1:0] RESET_PC = 16'h0000;
    localparam logic [3:0] OPC_HLT = 4'hF;

    typedef enum logic [1:0] {
        ST_FETCH  = 2'd0,
        ST_WAIT   = 2'd1,
        ST_DRAIN  = 2'd2,
        ST_HALTED = 2'd3
    } fetch_state_e;

    function automatic logic [3:0] opcode_of(input logic [XLEN-1:0] instr);
        return instr[XLEN-1:XLEN-4];
    endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Instruction-memory request/response bus between the fetch stage (master)
// and the instruction memory (slave).
interface fetch_stage_if;
    import cpu_pkg::*;

    logic            req;
    logic [XLEN-1:0] addr;
    logic            rvalid;
    logic [XLEN-1:0] rdata;

    modport master (output req, output addr, input rvalid, input rdata);
    modport slave  (input req, input addr, output rvalid, output rdata);

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding buffer that parks a fetched word while decode
// is stalled. Clear wins over load, load wins over unload.
module fetch_skid_buf (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_load,
    input  logic                     i_unload,
    input  logic                     i_clear,
    input  logic [cpu_pkg::XLEN-1:0] i_instr,
    input  logic [cpu_pkg::XLEN-1:0] i_pc,
    output logic                     o_full,
    output logic [cpu_pkg::XLEN-1:0] o_instr,
    output logic [cpu_pkg::XLEN-1:0] o_pc
);
    import cpu_pkg::*;

    logic            r_full;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] r_pc;

    // Buffer occupancy and payload.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_full  <= 1'b0;
            r_instr <= 16'h0000;
            r_pc    <= 16'h0000;
        end else if (i_clear) begin
            r_full <= 1'b0;
        end else if (i_load) begin
            r_full  <= 1'b1;
            r_instr <= i_instr;
            r_pc    <= i_pc;
        end else if (i_unload) begin
            r_full <= 1'b0;
        end
    end

    assign o_full  = r_full;
    assign o_instr = r_instr;
    assign o_pc    = r_pc;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, talks to a variable-latency imem,
// feeds IF/ID and handles redirects and HLT. Optional squash counter: FETCH_PERF_CNT_EN.
module fetch_stage #(
    parameter logic [15:0] RESET_PC = cpu_pkg::RESET_PC,
    parameter logic [3:0]  OPC_HLT  = cpu_pkg::OPC_HLT
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_stall,
    input  logic                     i_redirect_valid,
    input  logic [cpu_pkg::XLEN-1:0] i_redirect_pc,
    fetch_stage_if.master            io_imem,
    output logic                     o_ifid_valid,
    output logic [cpu_pkg::XLEN-1:0] o_ifid_instr,
    output logic [cpu_pkg::XLEN-1:0] o_ifid_pc,
    output logic [cpu_pkg::XLEN-1:0] o_ifid_pc_inc,
    output logic                     o_fetch_halted,
    output logic [cpu_pkg::XLEN-1:0] o_pc_out,
    output logic [cpu_pkg::XLEN-1:0] o_perf_squash_cnt
);
    import cpu_pkg::*;

    fetch_state_e    r_state;
    fetch_state_e    w_state_nxt;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_req_addr;
    logic            r_ifid_valid;
    logic [XLEN-1:0] r_ifid_instr;
    logic [XLEN-1:0] r_ifid_pc;
    logic [XLEN-1:0] r_ifid_pc_inc;
    logic            r_fetch_halted;

    logic            w_buf_full;
    logic [XLEN-1:0] w_buf_instr;
    logic [XLEN-1:0] w_buf_pc;
    logic            w_rsp_accept;
    logic            w_halt_now;
    logic            w_issue;
    logic            w_buf_load;
    logic            w_buf_unload;
    logic            w_ifid_load;
    logic [XLEN-1:0] w_ifid_instr_nxt;
    logic [XLEN-1:0] w_ifid_pc_nxt;

    assign w_rsp_accept = (r_state == ST_WAIT) && io_imem.rvalid && !i_redirect_valid;
    assign w_halt_now   = w_rsp_accept && (opcode_of(io_imem.rdata) == OPC_HLT);

    // Issuing in the response cycle keeps a 1-cycle memory at one word per clock.
    assign w_issue = !i_rst
                   && ((r_state == ST_FETCH) || ((r_state == ST_WAIT) && io_imem.rvalid))
                   && !i_redirect_valid && !w_buf_full
                   && !(io_imem.rvalid && i_stall) && !w_halt_now;

    assign io_imem.req  = w_issue;
    assign io_imem.addr = r_pc;

    assign w_buf_load   = w_rsp_accept && i_stall;
    assign w_buf_unload = !i_redirect_valid && !i_stall && w_buf_full;
    assign w_ifid_load  = !i_redirect_valid && !i_stall && (w_buf_full || w_rsp_accept);

    // IF/ID source select: a parked word is always older than a fresh response.
    always_comb begin
        w_ifid_instr_nxt = io_imem.rdata;
        w_ifid_pc_nxt    = r_req_addr;
        if (w_buf_full) begin
            w_ifid_instr_nxt = w_buf_instr;
            w_ifid_pc_nxt    = w_buf_pc;
        end else begin
            w_ifid_instr_nxt = io_imem.rdata;
            w_ifid_pc_nxt    = r_req_addr;
        end
    end

    // Fetch FSM next-state.
    always_comb begin
        w_state_nxt = r_state;
        if (i_redirect_valid) begin
            if (((r_state == ST_WAIT) || (r_state == ST_DRAIN)) && !io_imem.rvalid) begin
                w_state_nxt = ST_DRAIN;
            end else begin
                w_state_nxt = ST_FETCH;
            end
        end else begin
            case (r_state)
                ST_FETCH:  w_state_nxt = w_issue ? ST_WAIT : ST_FETCH;
                ST_WAIT: begin
                    if (!io_imem.rvalid) begin
                        w_state_nxt = ST_WAIT;
                    end else if (w_halt_now) begin
                        w_state_nxt = ST_HALTED;
                    end else if (w_issue) begin
                        w_state_nxt = ST_WAIT;
                    end else begin
                        w_state_nxt = ST_FETCH;
                    end
                end
                ST_DRAIN:  w_state_nxt = io_imem.rvalid ? ST_FETCH : ST_DRAIN;
                ST_HALTED: w_state_nxt = ST_HALTED;
                default:   w_state_nxt = ST_FETCH;
            endcase
        end
    end

    // State, PC and the address of the outstanding request.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_FETCH;
            r_pc       <= RESET_PC;
            r_req_addr <= 16'h0000;
        end else begin
            r_state <= w_state_nxt;
            if (i_redirect_valid) begin
                r_pc <= i_redirect_pc;
            end else if (w_issue) begin
                r_pc       <= r_pc + 16'h0002;
                r_req_addr <= r_pc;
            end
        end
    end

    // IF/ID register and halt flag; a bubble only drops the valid bit.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ifid_valid   <= 1'b0;
            r_ifid_instr   <= 16'h0000;
            r_ifid_pc      <= 16'h0000;
            r_ifid_pc_inc  <= 16'h0000;
            r_fetch_halted <= 1'b0;
        end else if (i_redirect_valid) begin
            r_ifid_valid   <= 1'b0;
            r_fetch_halted <= 1'b0;
        end else if (!i_stall) begin
            r_ifid_valid <= w_ifid_load;
            if (w_ifid_load) begin
                r_ifid_instr  <= w_ifid_instr_nxt;
                r_ifid_pc     <= w_ifid_pc_nxt;
                r_ifid_pc_inc <= w_ifid_pc_nxt + 16'h0002;
                if (opcode_of(w_ifid_instr_nxt) == OPC_HLT) begin
                    r_fetch_halted <= 1'b1;
                end
            end
        end
    end

    fetch_skid_buf u_skid (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_load   (w_buf_load),
        .i_unload (w_buf_unload),
        .i_clear  (i_redirect_valid),
        .i_instr  (io_imem.rdata),
        .i_pc     (r_req_addr),
        .o_full   (w_buf_full),
        .o_instr  (w_buf_instr),
        .o_pc     (w_buf_pc)
    );

`ifdef FETCH_PERF_CNT_EN
    logic [1:0]      w_squash_inc;
    logic [XLEN:0]   w_squash_sum;
    logic [XLEN-1:0] r_squash_cnt;

    // One squash per flushed IF/ID entry, flushed buffer entry and dropped response.
    always_comb begin
        w_squash_inc = 2'd0;
        if (i_redirect_valid) begin
            w_squash_inc = {1'b0, r_ifid_valid} + {1'b0, w_buf_full};
        end else begin
            w_squash_inc = 2'd0;
        end
        if ((r_state == ST_DRAIN) && io_imem.rvalid) begin
            w_squash_inc = w_squash_inc + 2'd1;
        end else begin
            w_squash_inc = w_squash_inc;
        end
        w_squash_sum = {1'b0, r_squash_cnt} + {15'd0, w_squash_inc};
    end

    // Saturating squash counter.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_squash_cnt <= 16'h0000;
        end else begin
            r_squash_cnt <= w_squash_sum[XLEN] ? 16'hFFFF : w_squash_sum[XLEN-1:0];
        end
    end

    assign o_perf_squash_cnt = r_squash_cnt;
`else
    assign o_perf_squash_cnt = 16'h0000;
`endif

    assign o_ifid_valid   = r_ifid_valid;
    assign o_ifid_instr   = r_ifid_instr;
    assign o_ifid_pc      = r_ifid_pc;
    assign o_ifid_pc_inc  = r_ifid_pc_inc;
    assign o_fetch_halted = r_fetch_halted;
    assign o_pc_out       = r_pc;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed scenarios plus randomized
// stall/redirect/reset/latency traffic against a transaction-level reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall;
    logic        redir;
    logic [15:0] redir_pc;
    logic        ifid_valid;
    logic [15:0] ifid_instr;
    logic [15:0] ifid_pc;
    logic [15:0] ifid_pc_inc;
    logic        fetch_halted;
    logic [15:0] pc_out;
    logic [15:0] perf_cnt;

    fetch_stage_if bus ();

    fetch_stage dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_stall           (stall),
        .i_redirect_valid  (redir),
        .i_redirect_pc     (redir_pc),
        .io_imem           (bus),
        .o_ifid_valid      (ifid_valid),
        .o_ifid_instr      (ifid_instr),
        .o_ifid_pc         (ifid_pc),
        .o_ifid_pc_inc     (ifid_pc_inc),
        .o_fetch_halted    (fetch_halted),
        .o_pc_out          (pc_out),
        .o_perf_squash_cnt (perf_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;

    // memory model: one pending response at a time
    logic        mem_pend = 1'b0;
    int          mem_due = 0;
    logic [15:0] mem_addr = 16'h0000;
    int          lat_min = 1;
    int          lat_max = 1;
    logic [15:0] hlt_addr = 16'h0001;

    // reference model of the fetch stage
    logic        m_busy;
    logic        m_discard;
    logic        m_stopped;
    logic [15:0] m_pc;
    logic [15:0] m_req_pc;
    logic [15:0] m_skid_i[$];
    logic [15:0] m_skid_p[$];
    logic        m_if_v;
    logic [15:0] m_if_i;
    logic [15:0] m_if_p;
    logic [15:0] m_if_inc;
    logic        m_halted;
    int          m_squash;

    task automatic check_val(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [15:0] word_at(input logic [15:0] a);
        logic [15:0] w;
        if (a == hlt_addr) return 16'hF000;
        w = 16'h1123 + 16'(32'(a >> 1) * 32'h1333);
        if (w[15:12] == 4'hF) w[15:12] = 4'hE;
        return w;
    endfunction

    task automatic model_reset();
        m_busy = 1'b0; m_discard = 1'b0; m_stopped = 1'b0;
        m_pc = 16'h0000; m_req_pc = 16'h0000;
        m_skid_i.delete(); m_skid_p.delete();
        m_if_v = 1'b0; m_if_i = 16'h0000; m_if_p = 16'h0000; m_if_inc = 16'h0000;
        m_halted = 1'b0; m_squash = 0;
    endtask

    task automatic cycle(input logic rst_v, input logic stall_v, input logic redir_v,
                         input logic [15:0] rpc_v);
        logic rv, acc, hlt, exp_req, ld;
        logic [15:0] rd, ld_i, ld_p;
        rst = rst_v; stall = stall_v; redir = redir_v; redir_pc = rpc_v;
        if (rst_v) mem_pend = 1'b0;
        rv = mem_pend && (cyc == mem_due);
        rd = rv ? word_at(mem_addr) : 16'($urandom);
        bus.rvalid = rv;
        bus.rdata  = rd;
        #1;
        acc = 1'b0; hlt = 1'b0; exp_req = 1'b0;
        if (!rst_v) begin
            acc = m_busy && !m_discard && rv && !redir_v;
            hlt = acc && (rd[15:12] == 4'hF);
            exp_req = ((!m_busy && !m_stopped) || (m_busy && !m_discard && rv))
                      && !redir_v && (m_skid_i.size() == 0) && !(rv && stall_v) && !hlt;
        end
        check_val("imem_req", 16'(bus.req), 16'(exp_req));
        if (exp_req) check_val("imem_addr", bus.addr, m_pc);
        if (rv) mem_pend = 1'b0;
        if (exp_req) begin
            mem_pend = 1'b1;
            mem_due  = cyc + int'($urandom_range(lat_min, lat_max));
            mem_addr = m_pc;
        end
        if (rst_v) begin
            model_reset();
        end else if (redir_v) begin
            m_squash += int'(m_if_v) + m_skid_i.size() + ((m_busy && m_discard && rv) ? 1 : 0);
            m_if_v = 1'b0;
            m_skid_i.delete(); m_skid_p.delete();
            m_pc = rpc_v; m_halted = 1'b0; m_stopped = 1'b0;
            m_discard = m_busy && !rv;
            m_busy    = m_busy && !rv;
        end else begin
            if (m_busy && m_discard && rv) begin
                m_squash++; m_busy = 1'b0; m_discard = 1'b0;
            end
            if (acc) begin
                m_busy = 1'b0;
                if (stall_v) begin m_skid_i.push_back(rd); m_skid_p.push_back(m_req_pc); end
                if (hlt) m_stopped = 1'b1;
            end
            if (!stall_v) begin
                ld = 1'b0; ld_i = 16'h0000; ld_p = 16'h0000;
                if (m_skid_i.size() != 0) begin
                    ld = 1'b1; ld_i = m_skid_i.pop_front(); ld_p = m_skid_p.pop_front();
                end else if (acc) begin
                    ld = 1'b1; ld_i = rd; ld_p = m_req_pc;
                end
                m_if_v = ld;
                if (ld) begin
                    m_if_i = ld_i; m_if_p = ld_p; m_if_inc = ld_p + 16'h0002;
                    if (ld_i[15:12] == 4'hF) m_halted = 1'b1;
                end
            end
            if (exp_req) begin
                m_busy = 1'b1; m_req_pc = m_pc; m_pc = m_pc + 16'h0002;
            end
        end
        if (m_squash > 65535) m_squash = 65535;
        @(posedge clk);
        #1;
        check_val("ifid_valid", 16'(ifid_valid), 16'(m_if_v));
        check_val("ifid_instr", ifid_instr, m_if_i);
        check_val("ifid_pc", ifid_pc, m_if_p);
        check_val("ifid_pc_inc", ifid_pc_inc, m_if_inc);
        check_val("fetch_halted", 16'(fetch_halted), 16'(m_halted));
        check_val("pc_out", pc_out, m_pc);
`ifdef FETCH_PERF_CNT_EN
        check_val("perf_squash", perf_cnt, 16'(m_squash));
`else
        check_val("perf_squash", perf_cnt, 16'h0000);
`endif
        @(negedge clk);
        cyc++;
    endtask

    initial begin
        logic r_v, s_v, d_v;
        logic [15:0] p_v;
        model_reset();
        // reset, then 1-cycle memory streaming
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        cycle(1'b1, 1'b0, 1'b0, 16'h0000);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // stall while the 0x0004 response arrives
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        check_val("stall_hold_pc", ifid_pc, 16'h0002);
        repeat (2) cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        check_val("release_pc", ifid_pc, 16'h0004);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // 3-cycle memory, redirect while a request is outstanding
        lat_min = 3; lat_max = 3;
        cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        cycle(1'b0, 1'b0, 1'b1, 16'h0040);
        check_val("redir_flush", 16'(ifid_valid), 16'h0000);
        repeat (8) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // HLT at 0x000A
        lat_min = 1; lat_max = 1; hlt_addr = 16'h000A;
        cycle(1'b0, 1'b0, 1'b1, 16'h0008);
        repeat (10) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        check_val("hlt_flag", 16'(fetch_halted), 16'h0001);
        check_val("hlt_ifid_pc", ifid_pc, 16'h000A);
        check_val("hlt_pc_out", pc_out, 16'h000C);
        cycle(1'b0, 1'b0, 1'b1, 16'h0020);
        check_val("hlt_leave", 16'(fetch_halted), 16'h0000);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // PC wrap
        hlt_addr = 16'h0001;
        cycle(1'b0, 1'b0, 1'b1, 16'hFFFE);
        repeat (4) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // redirect together with stall, buffer full
        cycle(1'b0, 1'b1, 1'b0, 16'h0000);
        cycle(1'b0, 1'b1, 1'b1, 16'h0100);
        check_val("redir_stall_flush", 16'(ifid_valid), 16'h0000);
        repeat (3) cycle(1'b0, 1'b0, 1'b0, 16'h0000);
        // randomized traffic
        lat_min = 1; lat_max = 4;
        for (int i = 0; i < 3000; i++) begin
            r_v = ($urandom_range(0, 199) == 0);
            s_v = ($urandom_range(0, 9) < 3);
            d_v = ($urandom_range(0, 15) == 0);
            p_v = ($urandom_range(0, 19) == 0) ? 16'hFFFE : 16'($urandom_range(0, 31) * 2);
            if ($urandom_range(0, 79) == 0) hlt_addr = 16'($urandom_range(0, 31) * 2);
            cycle(r_v, s_v, d_v, p_v);
        end
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
